// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between pc_sequencer, the instruction ROM and the decode stage.
// master is the sequencer's view; slave is the surrounding pipeline/ROM view.
interface pc_sequencer_if #(
    parameter int PC_W = 8
);
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            resume;
    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
    logic            if_valid;
    logic [15:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            halted;
    logic [15:0]     fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, resume, instr,
        output pc, if_valid, if_instr, if_pc, halted, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, resume, instr,
        input  pc, if_valid, if_instr, if_pc, halted, fetch_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: drives the ROM address and fills the IF/ID slot,
// handling stall, redirect, halt/resume and a saturating delivered-instruction count.
//
// state | meaning
// INIT  | one cycle after reset; pc parked at RESET_PC, nothing fetched
// RUN   | fetching one instruction per cycle unless stalled or redirected
// HALT  | HALT opcode delivered; fetch frozen until resume or redirect
module pc_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic           clk,
    input  logic           reset_n,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {INIT, RUN, HALT} state_t;

    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [15:0]     CNT_MAX = 16'hFFFF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic            halted_q, halted_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     count_inc;

    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= INIT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= 16'h0000;
            if_pc_q  <= RESET_PC;
            halted_q <= 1'b0;
            count_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            if_pc_q  <= if_pc_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        if_pc_d  = if_pc_q;
        halted_d = halted_q;
        count_d  = count_q;
        unique case (state_q)
            INIT: begin
                valid_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    instr_d = bus.instr;
                    if_pc_d = pc_q;
                    valid_d = 1'b1;
                    count_d = count_inc;
                    // A HALT word is delivered like any other, but the pc parks on it
                    if (bus.instr[15:12] == HALT_OP) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (bus.redirect) begin
                    pc_d     = bus.redirect_pc;
                    halted_d = 1'b0;
                    state_d  = RUN;
                end else if (bus.resume) begin
                    pc_d     = pc_q + PC_ONE;
                    halted_d = 1'b0;
                    state_d  = RUN;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.if_valid    = valid_q;
    assign bus.if_instr    = instr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;
endmodule
